// File: rtl/ps2_scan_framer.sv
// ps2_scan_framer
//   Collapses PS/2 set-2 prefix sequences (E0, F0, E0 F0) from the receiver's byte
//   stream into 10-bit key events {brk, ext, code[7:0]}. The events are buffered in a
//   first-word-fall-through FIFO. The interrupt is asserted while events are pending.
//
//   Optional feature (macro PS2_FRAMER_TIMEOUT_EN): an idle watchdog that abandons a
//   prefix after TIMEOUT_CYCLES clocks with no byte, returning to idle and setting seq_err.
//
// Ports
//   clk_i        system clock, rising edge
//   reset_ni     synchronous active-low reset
//   rx_valid_i   one-cycle strobe, rx_data_i holds a received byte
//   rx_data_i    received scan-code byte
//   rd_pop_i     one-cycle strobe, discard the head event
//   ovf_clr_i    one-cycle strobe, clear overflow_o and seq_err_o
//   evt_o        head event {brk, ext, code}, 0 when empty
//   empty_o      FIFO holds no events
//   full_o       FIFO holds 2^AW events
//   count_o      number of stored events
//   overflow_o   sticky, an event was dropped because the FIFO was full
//   seq_err_o    sticky, an illegal prefix sequence (or prefix timeout) was seen
//   irq_o        level interrupt, equal to ~empty_o
module ps2_scan_framer #(
    parameter int unsigned AW             = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          rx_valid_i,
    input  logic [7:0]    rx_data_i,
    input  logic          rd_pop_i,
    input  logic          ovf_clr_i,
    output logic [9:0]    evt_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic          seq_err_o,
    output logic          irq_o
);

    localparam int unsigned Depth    = 2 ** AW;
    localparam logic [AW:0] DepthCnt = (AW + 1)'(Depth);
    localparam logic [7:0]  ByteExt  = 8'hE0;
    localparam logic [7:0]  ByteBrk  = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } state_e;

    state_e          state_q, state_d;
    logic            push_req;
    logic [9:0]      push_evt;
    logic            seq_err_set;

    logic [9:0]      mem_q [Depth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            seq_err_q, seq_err_d;
    logic            pop_ok, push_ok, ovf_set;

    logic            is_prefix;
    assign is_prefix = (rx_data_i == ByteExt) || (rx_data_i == ByteBrk);

`ifdef PS2_FRAMER_TIMEOUT_EN
    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;

    // Fires on the TIMEOUT_CYCLES-th consecutive idle clock spent inside a prefix.
    assign tmo_hit = !rx_valid_i && (state_q != StIdle) && (tmo_cnt_q == TmoLast);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (rx_valid_i || state_q == StIdle || tmo_hit) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Framer next-state and push decode.
    always_comb begin
        state_d     = state_q;
        push_req    = 1'b0;
        push_evt    = {2'b00, rx_data_i};
        seq_err_set = 1'b0;
        if (rx_valid_i) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data_i == ByteExt) begin
                        state_d = StExt;
                    end else if (rx_data_i == ByteBrk) begin
                        state_d = StBrk;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_data_i == ByteBrk) begin
                        state_d = StExtBrk;
                    end else if (rx_data_i != ByteExt) begin
                        push_req = 1'b1;
                        push_evt = {2'b01, rx_data_i};
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    if (is_prefix) begin
                        seq_err_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_evt = {2'b10, rx_data_i};
                    end
                end
                StExtBrk: begin
                    state_d = StIdle;
                    if (is_prefix) begin
                        seq_err_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        push_evt = {2'b11, rx_data_i};
                    end
                end
            endcase
        end
`ifdef PS2_FRAMER_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d     = StIdle;
            seq_err_set = 1'b1;
        end
`endif
    end

    // FIFO control. A pop frees the slot a same-cycle push needs when full;
    // a pop while empty is dropped so the push still lands.
    always_comb begin
        pop_ok  = rd_pop_i && (count_q != '0);
        push_ok = push_req && ((count_q != DepthCnt) || pop_ok);
        ovf_set = push_req && !push_ok;

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A set event beats a same-cycle clear.
        overflow_d = ovf_set     || (overflow_q && !ovf_clr_i);
        seq_err_d  = seq_err_set || (seq_err_q  && !ovf_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // Storage has no reset; contents are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (reset_ni && push_ok) begin
            mem_q[wr_ptr_q] <= push_evt;
        end
    end

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DepthCnt);
    assign count_o    = count_q;
    assign evt_o      = empty_o ? 10'd0 : mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;
    assign seq_err_o  = seq_err_q;
    assign irq_o      = !empty_o;

endmodule

// File: tb/tb_ps2_scan_framer.sv
// Self-checking bench for ps2_scan_framer: directed steps followed by random byte/pop
// traffic, all checked against a queue-based reference model.
module tb_ps2_scan_framer;

    localparam int unsigned AW    = 4;
    localparam int unsigned Depth = 16;
    localparam int unsigned Tmo   = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rd_pop = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [9:0]    evt;
    logic          empty, full, overflow, seq_err, irq;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    ps2_scan_framer #(
        .AW             (AW),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rd_pop_i   (rd_pop),
        .ovf_clr_i  (ovf_clr),
        .evt_o      (evt),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .overflow_o (overflow),
        .seq_err_o  (seq_err),
        .irq_o      (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: event queue, pending prefix bytes, sticky flags.
    logic [9:0] mq[$];
    logic [7:0] pre[$];
    bit         m_ovf = 1'b0;
    bit         m_serr = 1'b0;
`ifdef PS2_FRAMER_TIMEOUT_EN
    int         m_idle = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit pre_has(input logic [7:0] b);
        foreach (pre[i]) if (pre[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] d, input bit pop, input bit clr);
        bit         push = 1'b0;
        bit         serr_set = 1'b0;
        bit         ovf_set = 1'b0;
        logic [9:0] e = '0;
        if (v) begin
`ifdef PS2_FRAMER_TIMEOUT_EN
            m_idle = 0;
`endif
            if (d == 8'hE0 || d == 8'hF0) begin
                // Anything following a break prefix must be a real code.
                if (pre_has(8'hF0)) begin
                    pre.delete();
                    serr_set = 1'b1;
                end else begin
                    pre.push_back(d);
                end
            end else begin
                e    = {pre_has(8'hF0), pre_has(8'hE0), d};
                push = 1'b1;
                pre.delete();
            end
        end
`ifdef PS2_FRAMER_TIMEOUT_EN
        else if (pre.size() != 0) begin
            m_idle++;
            if (m_idle == Tmo) begin
                pre.delete();
                serr_set = 1'b1;
                m_idle   = 0;
            end
        end
`endif
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < Depth) mq.push_back(e);
            else ovf_set = 1'b1;
        end
        m_ovf  = ovf_set  || (m_ovf  && !clr);
        m_serr = serr_set || (m_serr && !clr);
    endtask

    task automatic check_all(input string tag);
        int unsigned n = mq.size();
        check({tag, ".evt"},   32'(evt),      (n > 0) ? 32'(mq[0]) : 32'd0);
        check({tag, ".count"}, 32'(count),    n);
        check({tag, ".empty"}, 32'(empty),    32'(n == 0));
        check({tag, ".full"},  32'(full),     32'(n == Depth));
        check({tag, ".irq"},   32'(irq),      32'(n != 0));
        check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
        check({tag, ".serr"},  32'(seq_err),  32'(m_serr));
    endtask

    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit pop,
                        input bit clr);
        rx_valid = v;
        rx_data  = d;
        rd_pop   = pop;
        ovf_clr  = clr;
        @(posedge clk);
        #1;
        model_step(v, d, pop, clr);
        rx_valid = 1'b0;
        rd_pop   = 1'b0;
        ovf_clr  = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        // Busy inputs during reset must be ignored.
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h1C;
        rd_pop   = 1'b1;
        ovf_clr  = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        pre.delete();
        m_ovf  = 1'b0;
        m_serr = 1'b0;
`ifdef PS2_FRAMER_TIMEOUT_EN
        m_idle = 0;
`endif
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        rd_pop   = 1'b0;
        check_all(tag);
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst");
        check("rst.evt0", 32'(evt), 32'd0);
        check("rst.empty1", 32'(empty), 32'd1);

        // Plain make code, then pop.
        step("mk", 1'b1, 8'h1C, 1'b0, 1'b0);
        check("mk.evt", 32'(evt), 32'h01C);
        check("mk.irq", 32'(irq), 32'd1);
        step("mkpop", 1'b0, 8'h00, 1'b1, 1'b0);
        check("mkpop.empty", 32'(empty), 32'd1);

        // Extended break and plain break.
        step("eb0", 1'b1, 8'hE0, 1'b0, 1'b0);
        step("eb1", 1'b1, 8'hF0, 1'b0, 1'b0);
        step("eb2", 1'b1, 8'h75, 1'b0, 1'b0);
        check("eb.evt", 32'(evt), 32'h375);
        check("eb.count", 32'(count), 32'd1);
        step("br0", 1'b1, 8'hF0, 1'b0, 1'b0);
        step("br1", 1'b1, 8'h1C, 1'b0, 1'b0);
        step("brpop", 1'b0, 8'h00, 1'b1, 1'b0);
        check("br.evt", 32'(evt), 32'h21C);
        check("br.serr", 32'(seq_err), 32'd0);
        step("brpop2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Overfill with 17 bytes.
        for (int i = 1; i <= 17; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd16);
        check("fill.ovf", 32'(overflow), 32'd1);
        check("fill.head", 32'(evt), 32'h001);
        step("ovfclr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovfclr.ovf", 32'(overflow), 32'd0);

        // Push and pop together while full.
        step("fullpp", 1'b1, 8'h22, 1'b1, 1'b0);
        check("fullpp.count", 32'(count), 32'd16);
        check("fullpp.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 14; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check("drain.16th", 32'(evt), 32'h010);
        step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        check("drain.tail", 32'(evt), 32'h022);
        step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Push with pop on empty: push lands.
        step("emptypp", 1'b1, 8'h33, 1'b1, 1'b0);
        check("emptypp.evt", 32'(evt), 32'h033);
        step("emptypp.pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Illegal F0 E0, then clear, then confirm idle.
        step("se0", 1'b1, 8'hF0, 1'b0, 1'b0);
        step("se1", 1'b1, 8'hE0, 1'b0, 1'b0);
        check("se.serr", 32'(seq_err), 32'd1);
        check("se.count", 32'(count), 32'd0);
        step("seclr", 1'b0, 8'h00, 1'b0, 1'b1);
        check("seclr.serr", 32'(seq_err), 32'd0);
        step("seidle", 1'b1, 8'h1C, 1'b0, 1'b0);
        check("seidle.evt", 32'(evt), 32'h01C);
        step("seidle.pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Set beats a simultaneous clear.
        step("sc0", 1'b1, 8'hF0, 1'b0, 1'b0);
        step("sc1", 1'b1, 8'hF0, 1'b0, 1'b1);
        check("sc.serr", 32'(seq_err), 32'd1);
        step("sc.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-prefix discards it.
        step("rp0", 1'b1, 8'hE0, 1'b0, 1'b0);
        do_reset("rp.rst");
        step("rp1", 1'b1, 8'h1C, 1'b0, 1'b0);
        check("rp.evt", 32'(evt), 32'h01C);
        step("rp.pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Idle 100 cycles inside a prefix.
        step("to0", 1'b1, 8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step("toidle", 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef PS2_FRAMER_TIMEOUT_EN
        check("to.serr", 32'(seq_err), 32'd1);
`else
        check("to.serr", 32'(seq_err), 32'd0);
`endif
        step("to1", 1'b1, 8'h1C, 1'b0, 1'b0);
`ifdef PS2_FRAMER_TIMEOUT_EN
        check("to.evt", 32'(evt), 32'h01C);
`else
        check("to.evt", 32'(evt), 32'h11C);
`endif
        step("to.pop", 1'b0, 8'h00, 1'b1, 1'b1);

        // Random traffic, prefix-heavy, with varying drain rate.
        for (int i = 0; i < 3000; i++) begin
            bit          v   = ($urandom % 3) != 0;
            int unsigned sel = $urandom % 8;
            logic [7:0]  b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            bit          pop = (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 5) < 3);
            bit          clr = ($urandom % 32) == 0;
            if (($urandom % 600) == 0) do_reset("rnd.rst");
            else step("rnd", v, b, pop, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
